serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 87 ++++++++
 tb/tb_serial_adder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic full_sum,
    output logic full_carry
);

    assign full_sum   = a ^ b ^ cin;
    assign full_carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB first, one bit per clock through a single full-adder cell
// with a registered carry; result is held from the done pulse until the next accept.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .cin       (carry),
        .full_sum  (fa_sum),
        .full_carry(fa_carry)
    );

    assign start_ready = (state == IDLE) && rst_n;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // sum doubles as the result shift register; bit i lands at position i after WIDTH shifts
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= fa_carry;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 vector table and corner sequences,
// plus a WIDTH=2 instance driven back-to-back over every operand combination.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       rst_n, sv, cin8, sr, cout8, done8, busy8;
    logic [7:0] a8, b8, sum8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(sv),
        .start_ready(sr),
        .a          (a8),
        .b          (b8),
        .cin        (cin8),
        .sum        (sum8),
        .cout       (cout8),
        .done       (done8),
        .busy       (busy8)
    );

    // WIDTH=2 instance
    logic       rst2_n, sv2, cin2, sr2, cout2, done2, busy2;
    logic [1:0] a2, b2, sum2;

    serial_adder #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst2_n),
        .start_valid(sv2),
        .start_ready(sr2),
        .a          (a2),
        .b          (b2),
        .cin        (cin2),
        .sum        (sum2),
        .cout       (cout2),
        .done       (done2),
        .busy       (busy2)
    );

    typedef struct {
        logic [7:0] exp_sum;
        logic       exp_cout;
        int         acc;
    } sb8_t;

    typedef struct {
        logic [1:0] exp_sum;
        logic       exp_cout;
        int         acc;
    } sb2_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    sb8_t q8[$];
    sb2_t q2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting on DUT (t=%0t)", name, $time);
    endtask

    // Output monitors run 2 time units after each rising edge.
    logic prev_done8 = 1'b0;
    always @(posedge clk) begin
        sb8_t e;
        #2;
        if (rst_n) begin
            check("busy8_vs_ready", busy8, !sr);
            check("done8_pulse", done8 && prev_done8, 0);
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done8_unexpected: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    e = q8.pop_front();
                    check("sum8", sum8, e.exp_sum);
                    check("cout8", cout8, e.exp_cout);
                    check("latency8", cyc - e.acc, 8);
                end
            end
        end
        prev_done8 = rst_n ? done8 : 1'b0;
    end

    logic prev_done2 = 1'b0;
    always @(posedge clk) begin
        sb2_t e;
        #2;
        if (rst2_n) begin
            check("busy2_vs_ready", busy2, !sr2);
            check("done2_pulse", done2 && prev_done2, 0);
            if (done2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done2_unexpected: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    e = q2.pop_front();
                    check("sum2", sum2, e.exp_sum);
                    check("cout2", cout2, e.exp_cout);
                    check("latency2", cyc - e.acc, 2);
                end
            end
        end
        prev_done2 = rst2_n ? done2 : 1'b0;
    end

    // All driver code runs 1 time unit after a rising edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec);
        int n = 0;
        a8   = a;
        b8   = b;
        cin8 = c;
        sv   = 1'b1;
        while (!sr && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sr) begin
            fail_timeout("issue8");
            sv = 1'b0;
            return;
        end
        @(posedge clk); #1;
        q8.push_back('{exp_sum: es, exp_cout: ec, acc: cyc});
        sv = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((q8.size() != 0 || !sr) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q8.size() != 0 || !sr) fail_timeout("wait_idle8");
    endtask

    task automatic wait_idle2();
        int n = 0;
        while ((q2.size() != 0 || !sr2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q2.size() != 0 || !sr2) fail_timeout("wait_idle2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int   first_acc;
        int   prev_acc;
        int   n;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0; sv  = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst2_n = 1'b0; sv2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_done", done8, 0);
        check("rst_busy", busy8, 0);
        check("rst_ready", sr, 0);
        check("rst2_ready", sr2, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", sr, 1);
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 9; i++)
            issue8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
        wait_idle8();

        // start_valid held through RUN/DONE must not disturb the current operation
        issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        first_acc = cyc;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sv = 1'b1;
        n = 0;
        while (!sr && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sr) fail_timeout("hold_valid");
        else begin
            @(posedge clk); #1;
            q8.push_back('{exp_sum: 8'hFF, exp_cout: 1'b0, acc: cyc});
            check("accept_spacing8", cyc - first_acc, 10);
        end
        sv = 1'b0;
        wait_idle8();

        // Reset after three bits of RUN aborts without a done pulse
        issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        check("abort_done", done8, 0);
        check("abort_ready", sr, 1);
        @(posedge clk); #1;
        repeat (12) begin @(posedge clk); #1; end
        issue8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        wait_idle8();

        // WIDTH=2: all combinations back-to-back with start_valid held high
        rst2_n = 1'b1;
        @(posedge clk); #1;
        check("ready2_after_rst", sr2, 1);
        sv2 = 1'b1;
        prev_acc = 0;
        for (int c = 0; c < 32; c++) begin
            logic [4:0] cv;
            logic [2:0] full;
            cv   = 5'(c);
            a2   = cv[4:3];
            b2   = cv[2:1];
            cin2 = cv[0];
            full = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
            n = 0;
            while (!sr2 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (!sr2) begin
                fail_timeout("issue2");
                break;
            end
            @(posedge clk); #1;
            q2.push_back('{exp_sum: full[1:0], exp_cout: full[2], acc: cyc});
            if (c > 0) check("accept_spacing2", cyc - prev_acc, 4);
            prev_acc = cyc;
        end
        sv2 = 1'b0;
        wait_idle2();

        check("q8_drained", q8.size(), 0);
        check("q2_drained", q2.size(), 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
